bcd2bin_seq: RTL

Sequential BCD-to-binary converter (reverse double-dabble) for the display/input path. It accepts a packed multi-digit BCD word and produces the equivalent unsigned binary value. It resolves one bit per clock under a start/busy/done handshake. It sits between BCD-domain sources (digit entry, BCD counters) and binary arithmetic, and is the inverse of the combinational binary-to-BCD display converter.

---
 rtl/bcd2bin_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock.
// Optional macro BCD2BIN_RANGE_CHECK_EN builds the invalid-digit / overflow error flag.
module bcd2bin_seq #(
   parameter int width  = 6,
   parameter int digits = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [digits*4-1:0]   bcd,
   output logic [width-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int bcd_width = digits * 4;
   localparam int cnt_w     = $clog2(width + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state_q, state_d;
   logic [bcd_width-1:0]   sr_bcd_q, sr_bcd_d;
   logic [width-1:0]       sr_bin_q, sr_bin_d;
   logic [cnt_w-1:0]       cnt_q, cnt_d;
   logic [width-1:0]       bin_q, bin_d;
   logic [bcd_width+width-1:0] cat_shr;
   logic [bcd_width-1:0]   shift_bcd;
   logic [width-1:0]       shift_bin;
   logic                   load;

   // Undo the +3 of forward double-dabble: a digit that reads >= 8 after the shift gets -3.
   function automatic logic [bcd_width-1:0] digit_adjust(input logic [bcd_width-1:0] v);
      logic [bcd_width-1:0] r;
      r = v;
      for (int i = 0; i < digits; i++) begin
         if (v[i*4+3]) r[i*4 +: 4] = v[i*4 +: 4] - 4'd3;
      end
      return r;
   endfunction

`ifdef BCD2BIN_RANGE_CHECK_EN
   logic bad_q, bad_d;
   logic err_q, err_d;

   function automatic logic has_bad_digit(input logic [bcd_width-1:0] v);
      logic r;
      r = 1'b0;
      for (int i = 0; i < digits; i++) begin
         if (v[i*4 +: 4] > 4'd9) r = 1'b1;
      end
      return r;
   endfunction
`endif

   always_comb begin
      cat_shr   = {sr_bcd_q, sr_bin_q} >> 1;
      shift_bin = cat_shr[width-1:0];
      shift_bcd = digit_adjust(cat_shr[bcd_width+width-1:width]);
   end

   always_comb begin
      state_d  = state_q;
      sr_bcd_d = sr_bcd_q;
      sr_bin_d = sr_bin_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      load     = 1'b0;
`ifdef BCD2BIN_RANGE_CHECK_EN
      bad_d    = bad_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) load = 1'b1;
         end
         SHIFT: begin
            sr_bcd_d = shift_bcd;
            sr_bin_d = shift_bin;
            cnt_d    = cnt_q + cnt_w'(1);
            if (cnt_q == cnt_w'(width - 1)) begin
               bin_d   = shift_bin;
               state_d = DONE;
`ifdef BCD2BIN_RANGE_CHECK_EN
               // Residue left in sr_bcd means the value did not fit in width bits.
               err_d   = bad_q | (shift_bcd != '0);
`endif
            end
         end
         DONE: begin
            if (start) load = 1'b1;
            else       state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         state_d  = SHIFT;
         sr_bcd_d = bcd;
         sr_bin_d = '0;
         cnt_d    = '0;
`ifdef BCD2BIN_RANGE_CHECK_EN
         bad_d    = has_bad_digit(bcd);
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sr_bcd_q <= '0;
         sr_bin_q <= '0;
         cnt_q    <= '0;
         bin_q    <= '0;
      end else begin
         state_q  <= state_d;
         sr_bcd_q <= sr_bcd_d;
         sr_bin_q <= sr_bin_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
      end
   end

`ifdef BCD2BIN_RANGE_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bad_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         bad_q <= bad_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign bin  = bin_q;
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);

endmodule
